simprisc_mem_master: RTL and testbench
======================================

Name: simprisc_mem_master

Overview:
- Initiator side of the SimpRisc data-memory port: mem_addr, mem_wdata, mem_rw and mem_rdata, driven toward the memory responder.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Sequences the memory access: a one-cycle write strobe, or a fixed-latency read capture.
- Returns a response with read data and a misalignment error flag, and keeps wrapping transaction counters for debug.

Parameters:
DATA_W, 32, data bus width (mem_wdata, mem_rdata, req_wdata, rsp_rdata)
ADDR_W, 32, address width (mem_addr, req_addr)
RD_LATENCY, 1, cycles from mem_addr presented to mem_rdata valid; legal range 0..15
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  core request valid
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address; must be word aligned
req_wdata  input  DATA_W  store data
rsp_valid  output  1  response valid
rsp_ready  input  1  core accepts response
rsp_rdata  output  DATA_W  load data; 0 for stores and errors
rsp_err  output  1  misaligned access, no memory cycle performed
mem_addr  output  ADDR_W  address to memory
mem_wdata  output  DATA_W  write data to memory
mem_rw  output  1  1 = write strobe this cycle, 0 = read/idle
mem_rdata  input  DATA_W  read data from memory
wr_count  output  CNT_W  completed writes, wraps
rd_count  output  CNT_W  completed reads, wraps
err_count  output  CNT_W  error responses, wraps

Behaviour:
- Reset (sampled at clk edge, overrides everything):
  - State goes to IDLE.
  - req_ready=1 after reset.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_rw=0, mem_addr=0, mem_wdata=0.
  - All counters = 0.
  - Reset mid-transaction aborts it: no response is produced, and a pending write strobe is suppressed in the same cycle.
- States: IDLE, WRITE, READ_WAIT, RESP.
- IDLE:
  - req_ready=1; req_ready=0 in every other state.
  - Accept on req_valid && req_ready (cycle T); latch we/addr/wdata.
  - If req_addr[1:0] != 0: go to RESP with rsp_err=1, rsp_rdata=0. mem_rw stays 0 and mem_addr/mem_wdata are not updated.
  - Else if req_we=1: go to WRITE.
  - Else: go to READ_WAIT, with latency counter loaded to RD_LATENCY.
- WRITE (cycle T+1):
  - mem_rw=1, mem_addr=latched addr, mem_wdata=latched wdata, for exactly one cycle.
  - Go to RESP with rsp_err=0, rsp_rdata=0.
- READ_WAIT:
  - mem_addr=latched addr from T+1 onward; mem_rw=0.
  - Counter decrements each cycle; mem_rdata is sampled in the cycle where the counter reads 0.
  - RD_LATENCY=0: sample at T+1. RD_LATENCY=1: sample at T+2. In general sample at T+1+RD_LATENCY.
  - The sampled value goes into rsp_rdata; then go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the handshake cycle, go to IDLE and increment exactly one counter (wr, rd or err).
  - rsp_valid drops the next cycle.
  - No new request is accepted in the handshake cycle; the earliest next accept is the following cycle.
- Resulting latency with rsp_ready tied 1:
  - Store: rsp_valid at T+2.
  - Load: rsp_valid at T+2+RD_LATENCY.
  - Error: rsp_valid at T+1.
- Outside a write: mem_addr and mem_wdata hold their last driven values; mem_rw=0.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation.
- req_* signals are ignored when req_ready=0.
- Input changes after acceptance have no effect on the transaction in flight.

Test Plan:
- After reset, store addr=0x0000_0010 data=0xDEAD_BEEF with rsp_ready=1 -> mem_rw=1 for exactly one cycle at T+1 with mem_addr=0x10 and mem_wdata=0xDEADBEEF; rsp_valid at T+2 with rsp_err=0; wr_count=1.
- Load addr=0x20 with RD_LATENCY=1 and the memory model returning 0x1234_5678 at T+2 -> rsp_valid at T+3, rsp_rdata=0x12345678, mem_rw=0 throughout, rd_count=1; repeat with RD_LATENCY=0 and RD_LATENCY=3 -> rsp_valid at T+2 and T+5 respectively.
- Store to addr=0x13 -> no mem_rw pulse and mem_addr unchanged; rsp_valid at T+1 with rsp_err=1, rsp_rdata=0; err_count=1.
- Hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid and rsp_rdata stable, req_ready=0, new req_valid ignored; after rsp_ready=1, req_ready=1 the next cycle.
- Assert reset in the WRITE cycle of a store -> mem_rw=0 on that edge, no response, counters=0, req_ready=1 the next cycle.
- Issue 65536 stores with CNT_W=16 -> wr_count wraps to 0; back-to-back requests with req_valid held high are each accepted in the cycle after the previous response handshake.

Source files
------------

// File: rtl/simprisc_mem_master.sv
// SimpRisc data-memory initiator: one load/store at a time from the core,
// a single-cycle write strobe or fixed-latency read capture, then a response.
module simprisc_mem_master #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                we_q, we_d;

    logic                req_ready_d;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                rsp_err_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                mem_rw_d;
    logic [CNT_W-1:0]    wr_count_d, rd_count_d, err_count_d;

    logic                accept_c;
    logic                misaligned_c;

    assign accept_c     = (state_q == IDLE) && req_valid && req_ready;
    assign misaligned_c = (req_addr[1:0] != 2'b00);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        we_d        = we_q;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_rw_d    = 1'b0;
        wr_count_d  = wr_count;
        rd_count_d  = rd_count;
        err_count_d = err_count;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept_c) begin
                    req_ready_d = 1'b0;
                    we_d        = req_we;
                    if (misaligned_c) begin
                        // No memory cycle: memory-side outputs keep their values.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (req_we) begin
                        state_d     = WRITE;
                        mem_rw_d    = 1'b1;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = READ_WAIT;
                        lat_d      = LAT_W'(RD_LATENCY);
                        mem_addr_d = req_addr;
                    end
                end
            end

            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end

            READ_WAIT: begin
                if (lat_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = mem_rdata;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    if (rsp_err) begin
                        err_count_d = err_count + CNT_W'(1);
                    end else if (we_q) begin
                        wr_count_d = wr_count + CNT_W'(1);
                    end else begin
                        rd_count_d = rd_count + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            we_q      <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            we_q      <= we_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_rw    <= mem_rw_d;
            wr_count  <= wr_count_d;
            rd_count  <= rd_count_d;
            err_count <= err_count_d;
        end
    end

endmodule

// File: tb/tb_simprisc_mem_master.sv
// Scoreboard bench: three instances (read latency 1, 0, 3; the last with 4-bit counters).
module tb_simprisc_mem_master;

    localparam int NI = 3;

    logic        clk;
    int          cyc = 0;

    logic        reset     [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic        mem_rw    [NI];
    logic [31:0] mem_rdata [NI];
    logic [15:0] wr_count  [NI];
    logic [15:0] rd_count  [NI];
    logic [15:0] err_count [NI];

    typedef struct {
        int          inst;
        logic        we;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          rd_due  [NI];
    logic [31:0] rd_addr [NI];
    logic [31:0] rd_data [NI];
    int          wr_due  [NI];
    logic [31:0] wr_addr [NI];
    logic [31:0] wr_data [NI];
    int          exp_wr  [NI];
    int          exp_rd  [NI];
    int          exp_err [NI];
    int          last_hs [NI];
    logic        prev_valid [NI];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic int cmask(input int i);
        return (i == 2) ? 'hF : 'hFFFF;
    endfunction

    function automatic int find_exp(input int i);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k].inst == i) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=0x%08h want=0x%08h", name, i, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int i);
        checks++;
        errors++;
        $display("FAIL %s inst=%0d cyc=%0d", name, i, cyc);
    endtask

    // Instances: 0 = latency 1, 1 = latency 0, 2 = latency 3 with 4-bit counters.
    for (genvar g = 0; g < NI; g++) begin : g_inst
        if (g == 2) begin : g_small
            logic [3:0] wc, rc, ec;
            simprisc_mem_master #(.DATA_W(32), .ADDR_W(32), .RD_LATENCY(3), .CNT_W(4)) u_dut (
                .clk(clk), .reset(reset[g]),
                .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
                .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
                .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
                .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rw(mem_rw[g]),
                .mem_rdata(mem_rdata[g]),
                .wr_count(wc), .rd_count(rc), .err_count(ec)
            );
            assign wr_count[g]  = 16'(wc);
            assign rd_count[g]  = 16'(rc);
            assign err_count[g] = 16'(ec);
        end else begin : g_big
            simprisc_mem_master #(.DATA_W(32), .ADDR_W(32), .RD_LATENCY((g == 0) ? 1 : 0), .CNT_W(16)) u_dut (
                .clk(clk), .reset(reset[g]),
                .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
                .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
                .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
                .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rw(mem_rw[g]),
                .mem_rdata(mem_rdata[g]),
                .wr_count(wr_count[g]), .rd_count(rd_count[g]), .err_count(err_count[g])
            );
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: valid data only in the expected sample cycle at the expected address.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            mem_rdata[i] = ((cyc == rd_due[i]) && (mem_addr[i] == rd_addr[i]))
                           ? rd_data[i] : (32'hBAD0_0000 | 32'(cyc));
        end
    end

    // Monitor: write strobes and responses against the scoreboard.
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (!reset[i]) begin
                if (mem_rw[i]) begin
                    chk("strobe_cycle", i, 32'(cyc), 32'(wr_due[i]));
                    chk("strobe_addr", i, mem_addr[i], wr_addr[i]);
                    chk("strobe_data", i, mem_wdata[i], wr_data[i]);
                end
                if (rsp_valid[i]) begin
                    idx = find_exp(i);
                    if (idx < 0) begin
                        fail_now("unexpected_rsp", i);
                    end else begin
                        e = exp_q[idx];
                        if (!prev_valid[i]) chk("rsp_latency", i, 32'(cyc), 32'(e.due));
                        chk("rsp_rdata", i, rsp_rdata[i], e.rdata);
                        chk("rsp_err", i, 32'(rsp_err[i]), 32'(e.err));
                        if (rsp_ready[i]) begin
                            if (e.err)     exp_err[i] = (exp_err[i] + 1) & cmask(i);
                            else if (e.we) exp_wr[i]  = (exp_wr[i] + 1) & cmask(i);
                            else           exp_rd[i]  = (exp_rd[i] + 1) & cmask(i);
                            last_hs[i] = cyc;
                            exp_q.delete(idx);
                        end
                    end
                end
            end
            prev_valid[i] = rsp_valid[i];
        end
    end

    // Present a request at a negedge and hold it until accepted; returns accept cycle.
    task automatic issue(input int i, input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input bit keep, input bit want_rsp, output int acc);
        exp_t e;
        bit   err;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = data;
        acc = -1;
        for (int k = 0; k < 100; k++) begin
            if (req_ready[i]) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            fail_now("accept_timeout", i);
            req_valid[i] = 1'b0;
            return;
        end
        err = (addr[1:0] != 2'b00);
        if (!err && we) begin
            wr_due[i]  = acc + 1;
            wr_addr[i] = addr;
            wr_data[i] = data;
        end
        if (!err && !we) begin
            rd_due[i]  = acc + 1 + lat_of(i);
            rd_addr[i] = addr;
            rd_data[i] = data;
        end
        if (want_rsp) begin
            e.inst  = i;
            e.we    = we;
            e.err   = err;
            e.rdata = (err || we) ? 32'h0 : data;
            e.due   = acc + (err ? 1 : (we ? 2 : 2 + lat_of(i)));
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        bit done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (find_exp(i) < 0 && !rsp_valid[i]) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) fail_now("idle_timeout", i);
    endtask

    task automatic chk_counts(input int i);
        chk("wr_count", i, 32'(wr_count[i]), 32'(exp_wr[i]));
        chk("rd_count", i, 32'(rd_count[i]), 32'(exp_rd[i]));
        chk("err_count", i, 32'(err_count[i]), 32'(exp_err[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        bit seen;
        for (int i = 0; i < NI; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = 32'h0; req_wdata[i] = 32'h0; rsp_ready[i] = 1'b1;
            rd_due[i] = -1; rd_addr[i] = 32'h0; rd_data[i] = 32'h0;
            wr_due[i] = -1; wr_addr[i] = 32'h0; wr_data[i] = 32'h0;
            exp_wr[i] = 0; exp_rd[i] = 0; exp_err[i] = 0; last_hs[i] = -10;
            prev_valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) reset[i] = 1'b0;

        // Reset state
        for (int i = 0; i < NI; i++) begin
            chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
            chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("rst_rsp_rdata", i, rsp_rdata[i], 32'h0);
            chk("rst_rsp_err", i, 32'(rsp_err[i]), 32'd0);
            chk("rst_mem_rw", i, 32'(mem_rw[i]), 32'd0);
            chk("rst_mem_addr", i, mem_addr[i], 32'h0);
            chk("rst_mem_wdata", i, mem_wdata[i], 32'h0);
            chk_counts(i);
        end

        // Store, load, misaligned store on latency-1 instance
        issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
        wait_idle(0);
        chk("store_wr_count", 0, 32'(wr_count[0]), 32'd1);
        issue(0, 1'b0, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b1, acc);
        wait_idle(0);
        chk("load_rd_count", 0, 32'(rd_count[0]), 32'd1);
        issue(0, 1'b1, 32'h0000_0013, 32'h5555_AAAA, 1'b0, 1'b1, acc);
        wait_idle(0);
        chk("err_mem_addr_hold", 0, mem_addr[0], 32'h0000_0020);
        chk("err_mem_wdata_hold", 0, mem_wdata[0], 32'hDEAD_BEEF);
        chk("err_err_count", 0, 32'(err_count[0]), 32'd1);
        chk_counts(0);

        // Latency 0 and 3 instances
        issue(1, 1'b0, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b1, acc);
        wait_idle(1);
        issue(1, 1'b1, 32'h0000_0104, 32'h0F0F_F0F0, 1'b0, 1'b1, acc);
        wait_idle(1);
        chk_counts(1);
        issue(2, 1'b0, 32'h0000_0024, 32'hCAFE_F00D, 1'b0, 1'b1, acc);
        wait_idle(2);
        issue(2, 1'b1, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b1, acc);
        wait_idle(2);
        chk_counts(2);

        // Response back-pressure on a load; a new request must be ignored
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h0000_0030, 32'hA5A5_5A5A, 1'b0, 1'b1, acc);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (rsp_valid[0]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_now("stall_rsp_timeout", 0);
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1'b1; req_we[0] = 1'b1;
            req_addr[0] = 32'h0000_0044; req_wdata[0] = 32'h7777_7777;
            chk("stall_req_ready", 0, 32'(req_ready[0]), 32'd0);
            chk("stall_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("release_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("release_req_ready", 0, 32'(req_ready[0]), 32'd1);
        chk_counts(0);

        // Reset during the write strobe cycle
        issue(0, 1'b1, 32'h0000_0050, 32'h0BAD_CAFE, 1'b0, 1'b0, acc);
        chk("pre_reset_strobe", 0, 32'(mem_rw[0]), 32'd1);
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        exp_wr[0] = 0; exp_rd[0] = 0; exp_err[0] = 0;
        chk("rst_mid_mem_rw", 0, 32'(mem_rw[0]), 32'd0);
        chk("rst_mid_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("rst_mid_req_ready", 0, 32'(req_ready[0]), 32'd1);
        chk_counts(0);
        repeat (4) @(negedge clk);
        issue(0, 1'b1, 32'h0000_0060, 32'h1357_9BDF, 1'b0, 1'b1, acc);
        wait_idle(0);
        chk_counts(0);

        // Back-to-back stores with req_valid held high; 4-bit write counter wraps
        for (int k = 0; k < 16; k++) begin
            issue(2, 1'b1, 32'h0000_0100 + 32'(4 * k), 32'hF000_0000 | 32'(k), (k < 15), 1'b1, acc);
            if (k > 0) chk("b2b_accept_cycle", 2, 32'(acc), 32'(last_hs[2] + 1));
        end
        wait_idle(2);
        chk("wrap_wr_count", 2, 32'(wr_count[2]), 32'd0);
        chk_counts(2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
